// File: rtl/in_port_fifo.sv
// in_port_fifo: buffers device words for the processor's In_Port and raises an interrupt on a fill-level threshold crossing
module in_port_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int THRESH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          dev_data,
    input  logic                       dev_valid,
    output logic                       dev_ready,
    input  logic                       in_read,
    input  logic                       int_en,
    output logic [DATA_W-1:0]          In_Port,
    output logic                       fifo_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       underflow,
    output logic                       interupt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DP = CW'(DEPTH);
    localparam logic [CW-1:0] TH = CW'(THRESH);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_rd, r_wr;
    logic [CW-1:0]     r_count;
    logic              r_underflow, r_int;
    logic              w_push, w_pop, w_cross;
    logic [CW-1:0]     w_next;
    always_comb begin
        dev_ready  = reset && (r_count < DP);
        w_push     = dev_valid && dev_ready;
        w_pop      = in_read && (r_count != '0);
        w_next     = r_count + CW'(w_push) - CW'(w_pop);
        w_cross    = int_en && (r_count < TH) && (w_next >= TH);
        In_Port    = (r_count != '0) ? r_mem[r_rd] : '0;
        fifo_empty = (r_count == '0);
        count      = r_count;
        underflow  = r_underflow;
        interupt   = r_int;
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= dev_data;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd        <= '0;
            r_wr        <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
            r_int       <= 1'b0;
        end else begin
            r_rd        <= w_pop ? r_rd + AW'(1) : r_rd;
            r_wr        <= w_push ? r_wr + AW'(1) : r_wr;
            r_count     <= w_next;
            r_underflow <= r_underflow || (in_read && (r_count == '0));
            r_int       <= w_cross;
        end
    end
endmodule
